multicycle_control: RTL

//  Multi-cycle RV32I control FSM; successor to the single-cycle main decoder. Sequences FETCH/DECODE/EXEC/MEM/WB
//  per instruction class over shared ALU and memory. Stalls on the memory-ready handshake and traps on an illegal

---
 rtl/rv32i_ctrl_pkg.sv | 54 +++++
 rtl/main_decoder.sv | 30 +++
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared opcode constants, state/class enums and datapath mux encodings for the RV32I control path.
package rv32i_ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IALU   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_RFUNCT = 2'b10,
        ALU_IFUNCT = 2'b11
    } aluop_e;

    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,
        CLS_STORE  = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_RTYPE  = 3'd3,
        CLS_IALU   = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_JALR   = 3'd6,
        CLS_NONE   = 3'd7
    } instr_class_e;

    localparam logic [1:0] WB_ALUOUT   = 2'b00;
    localparam logic [1:0] WB_MDR      = 2'b01;
    localparam logic [1:0] WB_PC4      = 2'b10;
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;
    localparam logic [1:0] SRCA_OLDPC  = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode classifier shared by the single- and multi-cycle control paths.
// RV32_JUMP_EN: when defined, JAL/JALR classify as legal.
module main_decoder
    import rv32i_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output instr_class_e        cls,
    output logic                legal
);

    always_comb begin
        cls = CLS_NONE;
        case (opcode)
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_RTYPE:  cls = CLS_RTYPE;
            OP_IALU:   cls = CLS_IALU;
`ifdef RV32_JUMP_EN
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
`else
`endif
            default:   cls = CLS_NONE;
        endcase
    end

    assign legal = (cls != CLS_NONE);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready, traps.
// Jump support (JAL/JALR) is enabled by defining RV32_JUMP_EN.
module multicycle_control
    import rv32i_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W    = 2,
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                Branch,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic [1:0]          MemtoReg,
    output logic                RegWrite,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
    output logic                illegal,
    output logic                timeout
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [OPCODE_W-1:0]  opcode_q, opcode_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;
    logic [OPCODE_W-1:0]  dec_opcode;
    instr_class_e         cls;
    logic                 legal;
    aluop_e               aluop;
    logic                 unused_zero;

    // The BEQ decision is taken in the datapath (PCWrite | Branch & zero).
    assign unused_zero = zero;

    // Live opcode while classifying in DECODE; latched copy from EXEC onward.
    assign dec_opcode = (state_q == DECODE) ? opcode : opcode_q;

    main_decoder u_main_decoder (
        .opcode (dec_opcode),
        .cls    (cls),
        .legal  (legal)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        opcode_d   = opcode_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        case (state_q)
            FETCH, MEM: begin
                if (mem_ready) begin
                    if (state_q == FETCH)        state_d = DECODE;
                    else if (cls == CLS_LOAD)    state_d = WB;
                    else                         state_d = FETCH;
                end else if (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
                    state_d   = TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            DECODE: begin
                opcode_d = opcode;
                state_d  = legal ? EXEC : TRAP;
            end
            EXEC: begin
                case (cls)
                    CLS_LOAD, CLS_STORE:           state_d = MEM;
                    CLS_RTYPE, CLS_IALU:           state_d = WB;
                    CLS_BRANCH, CLS_JAL, CLS_JALR: state_d = FETCH;
                    default:                       state_d = TRAP;
                endcase
            end
            WB:      state_d = FETCH;
            default: state_d = TRAP;
        endcase
        if (state_d != state_q) wait_cnt_d = '0;
        if (state_d == TRAP && state_q != TRAP) illegal_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            opcode_q   <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            opcode_q   <= opcode_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Datapath control decode; everything reads 0 while rst is high and in TRAP.
    always_comb begin
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = WB_ALUOUT;
        RegWrite = 1'b0;
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_RS2;
        aluop    = ALU_ADD;
        PCSource = PCSRC_ALU;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                EXEC: begin
                    ALUSrcA = SRCA_RS1;
                    case (cls)
                        CLS_LOAD, CLS_STORE: ALUSrcB = SRCB_IMM;
                        CLS_RTYPE:           aluop   = ALU_RFUNCT;
                        CLS_IALU: begin
                            ALUSrcB = SRCB_IMM;
                            aluop   = ALU_IFUNCT;
                        end
                        CLS_BRANCH: begin
                            aluop    = ALU_SUB;
                            Branch   = 1'b1;
                            PCSource = PCSRC_ALUOUT;
                        end
                        CLS_JAL, CLS_JALR: begin
                            RegWrite = 1'b1;
                            MemtoReg = WB_PC4;
                            ALUSrcB  = SRCB_IMM;
                            PCWrite  = 1'b1;
                            if (cls == CLS_JAL) ALUSrcA = SRCA_OLDPC;
                            else                PCSource = PCSRC_JALR;
                        end
                        default: ALUSrcA = SRCA_PC;
                    endcase
                end
                MEM: begin
                    IorD     = 1'b1;
                    MemRead  = (cls == CLS_LOAD);
                    MemWrite = (cls == CLS_STORE);
                end
                WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (cls == CLS_LOAD) ? WB_MDR : WB_ALUOUT;
                end
                default: RegWrite = 1'b0;
            endcase
        end
    end

    assign ALUOp   = ALUOP_W'(aluop);
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule
